discrete_derivative_engine: RTL
===============================

Name: discrete_derivative_engine

Overview:
Parametrised sample-history processor between the ADC driver's channel-A output and the DAC driver's channel-B input.
- Keeps a DEPTH-entry shift history of signed samples.
- Selectable modes: bypass, N-sample delay, first difference, second difference, central difference.
- Applies a power-of-two gain with saturation.
- Registered output is provided both as 2's complement and as offset-binary DAC code, with a valid pulse and a history-primed flag.

Parameters:
W, 14, sample width (signed 2's complement), ≥ 4
DEPTH, 8, history length in samples, ≥ 3, power of 2
OUT_W, 12, DAC code width, ≤ W

Ports:
CLK_50M  in  1  system clock, all logic on rising edge
RST_N  in  1  asynchronous active-low reset
SAMPLE_STB  in  1  one-cycle strobe: DIN valid, accept sample
DIN  in  W  signed input sample
MODE  in  3  0 bypass, 1 delay, 2 first diff, 3 second diff, 4 central diff, 5-7 reserved
DELAY_SEL  in  log2(DEPTH)  tap index for mode 1
GAIN_SH  in  2  left-shift gain 0..3
CLEAR  in  1  synchronous flush of history and pipeline
DOUT  out  W  signed result
DOUT_DAC  out  OUT_W  offset-binary code {~DOUT[W-1], DOUT[W-2:W-OUT_W]}
DOUT_VALID  out  1  one-cycle pulse, new DOUT
SAT  out  1  result of current DOUT was clamped
PRIMED  out  1  DEPTH samples accepted since reset/clear

Behaviour:
Reset (RST_N low, async):
- History h[0..DEPTH-1] = 0; both pipeline stages invalid; sample count = 0.
- DOUT = 0, DOUT_DAC = 2^(OUT_W-1) (0x800 at defaults), DOUT_VALID = 0, SAT = 0, PRIMED = 0.
- Release mid-stream: first accepted STB after release behaves as the first sample after reset.

Stage 0, edge E where SAMPLE_STB = 1 and CLEAR = 0:
- h[0] ← DIN; h[k] ← h[k-1] for k ≥ 1.
- Count increments, saturating at DEPTH; PRIMED = 1 once count == DEPTH.
- MODE, DELAY_SEL and GAIN_SH are captured into stage-1 control at this edge. Changes between strobes never corrupt an in-flight sample.

Stage 1, edge E+1: raw result computed on the updated history, width W+3 signed.
- Mode 0: h0.
- Mode 1: h[DELAY_SEL]; DELAY_SEL = 0 is identical to bypass.
- Mode 2: h0 − h1.
- Mode 3: h0 − 2·h1 + h2.
- Mode 4: (h0 − h2) arithmetic shift right 1 (floor toward −inf).
- Modes 5-7: 0.

Stage 2, edge E+2:
- Compute raw << GAIN_SH in W+6 bits, then clamp to [−2^(W−1), 2^(W−1)−1].
- DOUT and DOUT_DAC registered; SAT = 1 if clamped, else 0.
- DOUT_VALID = 1 for exactly that cycle.
- DOUT, DOUT_DAC and SAT hold until the next valid result.

Latency and throughput:
- Latency is exactly 2 cycles from strobe edge to DOUT_VALID.
- Fully pipelined: back-to-back strobes give back-to-back valid pulses, in order.

Priming:
- Before PRIMED, unfilled taps read 0 and results are still produced.
- PRIMED is advisory; it does not gate DOUT_VALID.

CLEAR (synchronous, priority over SAMPLE_STB):
- Zeros the history, count and PRIMED.
- Invalidates both pipeline stages, so no DOUT_VALID occurs for in-flight samples.
- Sets DOUT = 0, DOUT_DAC = midscale, SAT = 0.
- A strobe in the same cycle as CLEAR is discarded.

Arithmetic:
- No intermediate overflow: W+3 bits cover all modes at full scale.
- SAT is the only place overflow is visible.

Test Plan:
1. Reset: assert RST_N = 0 asynchronously between edges -> outputs zero immediately, DOUT_DAC = 0x800, PRIMED = 0. Release, no strobes -> DOUT_VALID stays 0.
2. MODE = 2, GAIN_SH = 0, strobes with DIN = 100, 300, 250 -> DOUT = 100, 200, −50, each DOUT_VALID exactly 2 cycles after its strobe. Back-to-back strobes give 3 consecutive valid cycles.
3. Second and central difference:
   - MODE = 3, DIN = 0, 1000, 0 -> DOUT = 0, 1000, −2000.
   - MODE = 4, DIN = 0, 0, 101 -> final DOUT = 50.
   - MODE = 4, DIN = 0, 0, −101 -> final DOUT = −51.
4. Saturation:
   - MODE = 2, DIN = −8192 then 8191 -> second DOUT = 8191, SAT = 1, DOUT_DAC = 0xFFF.
   - Next DIN = 8191 -> DOUT = 0, SAT = 0.
   - MODE = 0, GAIN_SH = 3, DIN = −2000 -> DOUT = −8192, SAT = 1.
5. Delay and priming: MODE = 1, DELAY_SEL = 3, ramp DIN = 1..10 -> DOUT = 0, 0, 0, 1, 2, …, 7. PRIMED rises on the edge accepting sample 8. Changing MODE to 2 between strobes affects only later samples.
6. CLEAR:
   - CLEAR coincident with a strobe, with two samples in flight -> no further DOUT_VALID, DOUT = 0, PRIMED = 0.
   - Next MODE = 2 strobe, DIN = 50 -> DOUT = 50, showing the history is zeroed.

Source files
------------

// File: rtl/discrete_derivative_engine.sv
// discrete_derivative_engine
//   Sample-history processor: keeps a DEPTH-deep shift history of signed
//   samples and produces bypass / tap-delay / first, second or central
//   difference results, scaled by a power-of-two gain with saturation.
//   Latency is two clock edges from an accepted strobe to DOUT_VALID.
// Ports:
//   CLK_50M     system clock, rising edge
//   RST_N       asynchronous active-low reset
//   SAMPLE_STB  one-cycle strobe, DIN valid
//   DIN         signed input sample (W bits)
//   MODE        0 bypass, 1 delay, 2 first diff, 3 second diff, 4 central diff
//   DELAY_SEL   history tap for mode 1
//   GAIN_SH     left-shift gain 0..3
//   CLEAR       synchronous flush of history and pipeline (beats SAMPLE_STB)
//   DOUT        signed result
//   DOUT_DAC    offset-binary code of DOUT, OUT_W bits
//   DOUT_VALID  one-cycle pulse on each new DOUT
//   SAT         current DOUT was clamped
//   PRIMED      DEPTH samples accepted since reset/clear
module discrete_derivative_engine #(
    parameter int W     = 14,
    parameter int DEPTH = 8,
    parameter int OUT_W = 12
) (
    input  logic                     CLK_50M,
    input  logic                     RST_N,
    input  logic                     SAMPLE_STB,
    input  logic [W-1:0]             DIN,
    input  logic [2:0]               MODE,
    input  logic [$clog2(DEPTH)-1:0] DELAY_SEL,
    input  logic [1:0]               GAIN_SH,
    input  logic                     CLEAR,
    output logic [W-1:0]             DOUT,
    output logic [OUT_W-1:0]         DOUT_DAC,
    output logic                     DOUT_VALID,
    output logic                     SAT,
    output logic                     PRIMED
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int RW = W + 3;
    localparam int SW = W + 6;

    localparam logic signed [SW-1:0] C_MAX = (SW'(1) <<< (W - 1)) - SW'(1);
    localparam logic signed [SW-1:0] C_MIN = -C_MAX - SW'(1);

    typedef enum logic [2:0] {
        M_BYPASS  = 3'd0,
        M_DELAY   = 3'd1,
        M_DIFF1   = 3'd2,
        M_DIFF2   = 3'd3,
        M_CENTRAL = 3'd4
    } mode_t;

    logic [W-1:0]          r_hist [DEPTH];
    logic [CW-1:0]         r_cnt;

    logic                  r_s1_vld;
    logic [2:0]            r_s1_mode;
    logic [AW-1:0]         r_s1_dsel;
    logic [1:0]            r_s1_gain;

    logic                  r_s2_vld;
    logic signed [RW-1:0]  r_s2_raw;
    logic [1:0]            r_s2_gain;

    logic [W-1:0]          r_dout;
    logic                  r_vld;
    logic                  r_sat;

    logic signed [RW-1:0]  w_h0, w_h1, w_h2, w_hd;
    logic signed [RW-1:0]  w_raw;
    logic signed [SW-1:0]  w_shift;
    logic [W-1:0]          w_clamped;
    logic                  w_sat;

    // History shift register and fill counter
    always_ff @(posedge CLK_50M or negedge RST_N) begin
        if (!RST_N) begin
            for (int unsigned k = 0; k < DEPTH; k++) r_hist[k] <= '0;
            r_cnt <= '0;
        end else if (CLEAR) begin
            for (int unsigned k = 0; k < DEPTH; k++) r_hist[k] <= '0;
            r_cnt <= '0;
        end else if (SAMPLE_STB) begin
            r_hist[0] <= DIN;
            for (int unsigned k = 1; k < DEPTH; k++) r_hist[k] <= r_hist[k-1];
            if (r_cnt != CW'(DEPTH)) r_cnt <= r_cnt + CW'(1);
        end
    end

    assign PRIMED = (r_cnt == CW'(DEPTH));

    // Stage 1 control: captured with the sample so later MODE/GAIN changes
    // cannot affect an in-flight result
    always_ff @(posedge CLK_50M or negedge RST_N) begin
        if (!RST_N) begin
            r_s1_vld  <= 1'b0;
            r_s1_mode <= '0;
            r_s1_dsel <= '0;
            r_s1_gain <= '0;
        end else begin
            r_s1_vld <= SAMPLE_STB && !CLEAR;
            if (SAMPLE_STB && !CLEAR) begin
                r_s1_mode <= MODE;
                r_s1_dsel <= DELAY_SEL;
                r_s1_gain <= GAIN_SH;
            end
        end
    end

    assign w_h0 = {{3{r_hist[0][W-1]}}, r_hist[0]};
    assign w_h1 = {{3{r_hist[1][W-1]}}, r_hist[1]};
    assign w_h2 = {{3{r_hist[2][W-1]}}, r_hist[2]};
    assign w_hd = {{3{r_hist[r_s1_dsel][W-1]}}, r_hist[r_s1_dsel]};

    always_comb begin
        w_raw = '0;
        case (mode_t'(r_s1_mode))
            M_BYPASS:  w_raw = w_h0;
            M_DELAY:   w_raw = w_hd;
            M_DIFF1:   w_raw = w_h0 - w_h1;
            M_DIFF2:   w_raw = w_h0 - (w_h1 <<< 1) + w_h2;
            M_CENTRAL: w_raw = (w_h0 - w_h2) >>> 1;
            default:   w_raw = '0;
        endcase
    end

    always_ff @(posedge CLK_50M or negedge RST_N) begin
        if (!RST_N) begin
            r_s2_vld  <= 1'b0;
            r_s2_raw  <= '0;
            r_s2_gain <= '0;
        end else begin
            r_s2_vld <= r_s1_vld && !CLEAR;
            if (r_s1_vld) begin
                r_s2_raw  <= w_raw;
                r_s2_gain <= r_s1_gain;
            end
        end
    end

    // Gain and clamp; W+6 bits hold the largest raw value shifted by 3
    always_comb begin
        w_shift   = {{3{r_s2_raw[RW-1]}}, r_s2_raw} <<< r_s2_gain;
        w_sat     = 1'b0;
        w_clamped = w_shift[W-1:0];
        if (w_shift > C_MAX) begin
            w_sat     = 1'b1;
            w_clamped = C_MAX[W-1:0];
        end else if (w_shift < C_MIN) begin
            w_sat     = 1'b1;
            w_clamped = C_MIN[W-1:0];
        end
    end

    always_ff @(posedge CLK_50M or negedge RST_N) begin
        if (!RST_N) begin
            r_dout <= '0;
            r_sat  <= 1'b0;
            r_vld  <= 1'b0;
        end else if (CLEAR) begin
            r_dout <= '0;
            r_sat  <= 1'b0;
            r_vld  <= 1'b0;
        end else begin
            r_vld <= r_s2_vld;
            if (r_s2_vld) begin
                r_dout <= w_clamped;
                r_sat  <= w_sat;
            end
        end
    end

    assign DOUT       = r_dout;
    assign DOUT_VALID = r_vld;
    assign SAT        = r_sat;
    assign DOUT_DAC   = {~r_dout[W-1], r_dout[W-2:W-OUT_W]};

endmodule
